// File: rtl/first_ii_pkg.sv
// Shared constants and types for the first_ii 4-input function cell.
package first_ii_pkg;

  localparam logic [15:0] FIRST_II_DEFAULT_TT = 16'h0727;

  typedef logic [3:0] minterm_idx_t;

endpackage : first_ii_pkg

// File: rtl/first_ii_lut4.sv
// Combinational 4-input lookup: r is the truth-table bit selected by idx.
module lut4
  import first_ii_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = FIRST_II_DEFAULT_TT
) (
  input  minterm_idx_t idx,
  output logic         r
);

  always_comb begin
    r = TRUTH_TABLE[idx];
  end

endmodule : lut4

// File: rtl/first_ii.sv
// Registered 4-input Boolean function f(a,b,c,d) with synchronous reset.
module first_ii
  import first_ii_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = FIRST_II_DEFAULT_TT,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f
);

  minterm_idx_t idx;
  logic         r;

  assign idx = {a, b, c, d};

  lut4 #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut4 (
    .idx(idx),
    .r  (r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      f <= RESET_VALUE;
    end else begin
      f <= r;
    end
  end

endmodule : first_ii

// File: tb/tb_first_ii.sv
// Directed and randomized bench for first_ii covering default and overridden tables.
module tb_first_ii;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic f_def, f_hi, f_one, f_zero;

  int checks = 0;
  int errors = 0;

  first_ii dut_def (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f_def)
  );

  first_ii #(
    .TRUTH_TABLE(16'h8000),
    .RESET_VALUE(1'b1)
  ) dut_hi (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f_hi)
  );

  first_ii #(
    .TRUTH_TABLE(16'hFFFF)
  ) dut_one (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f_one)
  );

  first_ii #(
    .TRUTH_TABLE(16'h0000)
  ) dut_zero (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: default function is the minterm set {0,1,2,5,8,9,10}.
  function automatic logic model_default(input logic [3:0] v);
    return (v inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd8, 4'd9, 4'd10});
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] v, input logic r);
    check({tag, "/default"}, f_def,  r ? 1'b0 : model_default(v));
    check({tag, "/tt8000"},  f_hi,   r ? 1'b1 : (a & b & c & d));
    check({tag, "/ttFFFF"},  f_one,  r ? 1'b0 : 1'b1);
    check({tag, "/tt0000"},  f_zero, 1'b0);
  endtask

  // Present inputs and rst, clock once, then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic [3:0] v, input logic r);
    {a, b, c, d} = v;
    rst = r;
    @(posedge clk);
    #1;
    check_all(tag, v, r);
  endtask

  initial begin
    logic [3:0] v;
    logic       r;

    rst = 1'b1;
    {a, b, c, d} = 4'b1111;

    step("reset0", 4'b1111, 1'b1);
    step("reset1", 4'b1111, 1'b1);
    step("post_reset_m15", 4'b1111, 1'b0);

    for (int unsigned i = 0; i < 16; i++) begin
      step($sformatf("sweep_idx%0d", i), 4'(i), 1'b0);
    end

    step("spot_0101", 4'b0101, 1'b0);
    step("spot_0111", 4'b0111, 1'b0);
    step("spot_1010", 4'b1010, 1'b0);
    step("spot_1101", 4'b1101, 1'b0);

    for (int unsigned i = 0; i < 8; i++) begin
      step($sformatf("toggle%0d", i), (i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0);
    end

    for (int unsigned i = 0; i < 16; i++) begin
      step($sformatf("sweep_rst_idx%0d", i), 4'(i), (i == 8));
    end

    // A reset pulse that lies entirely between edges must not affect f.
    {a, b, c, d} = 4'b0000;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("between_edge_rst", 4'b0000, 1'b0);

    for (int unsigned i = 0; i < 200; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0);
      step($sformatf("rand%0d", i), v, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_first_ii
